// File: rtl/io_uart_pkg.sv
// Shared definitions for the J1 I/O-bus UART responder:
// register offsets, status bit positions and the UART FSM states.
package io_uart_pkg;

    localparam logic [15:0] OFS_DATA = 16'h0000;
    localparam logic [15:0] OFS_STAT = 16'h0004;

    localparam int ST_TX_IDLE  = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_RX_OVR   = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_FRM_ERR  = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX byte FIFO, first-word fall-through on dout.
// Ports: clk, reset, push/din, pop/dout, full, empty.
module uart_tx_fifo
    import io_uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot a full push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/io_uart_port.sv
// J1 I/O-bus responder with one 8N1 UART (TX FIFO + RX holding reg).
// Ports: clk, reset, memIo_addr/io_rd/io_wr/dout bus in, io_din
// registered read data, uart_rx serial in, uart_tx serial out.
module io_uart_port
    import io_uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 217,
    parameter int          TX_DEPTH     = 16,
    parameter logic [15:0] BASE_ADDR    = 16'h1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] memIo_addr,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [31:0] dout,
    output logic [31:0] io_din,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------- bus decode ----------------
    logic sel_data;
    logic sel_stat;
    logic wr_data;
    logic wr_stat;
    logic rd_data;

    assign sel_data = (memIo_addr == BASE_ADDR + OFS_DATA);
    assign sel_stat = (memIo_addr == BASE_ADDR + OFS_STAT);
    assign wr_data  = io_wr && sel_data;
    assign wr_stat  = io_wr && sel_stat;
    assign rd_data  = io_rd && sel_data;

    logic unused_dout;
    assign unused_dout = ^dout[31:8];

    // ---------------- TX FIFO ----------------
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       tx_pop;
    logic       tx_drop;

    uart_tx_fifo #(
        .DEPTH(TX_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (wr_data),
        .din  (dout[7:0]),
        .pop  (tx_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign tx_drop = wr_data && fifo_full && !tx_pop;

    // ---------------- TX FSM ----------------
    uart_state_t   tx_state;
    uart_state_t   tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bits;
    logic [7:0]    tx_shift;
    logic          tx_tick;

    assign tx_tick = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tx_state <= S_IDLE;
        else
            tx_state <= tx_next;
    end

    // STOP chains straight into the next START so that queued
    // bytes go out with no idle gap between frames.
    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            S_IDLE:
                if (!fifo_empty)
                    tx_next = S_START;
            S_START:
                if (tx_tick)
                    tx_next = S_DATA;
            S_DATA:
                if (tx_tick && tx_bits == 3'd7)
                    tx_next = S_STOP;
            S_STOP:
                if (tx_tick)
                    tx_next = fifo_empty ? S_IDLE : S_START;
        endcase
    end

    always_comb begin
        tx_pop  = 1'b0;
        uart_tx = 1'b1;
        unique case (tx_state)
            S_IDLE: begin
                tx_pop  = !fifo_empty;
            end
            S_START: begin
                uart_tx = 1'b0;
            end
            S_DATA: begin
                uart_tx = tx_shift[0];
            end
            S_STOP: begin
                tx_pop  = tx_tick && !fifo_empty;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '0;
        end else if (tx_pop) begin
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= fifo_dout;
        end else if (tx_state != S_IDLE) begin
            if (tx_tick) begin
                tx_cnt <= '0;
                if (tx_state == S_DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bits  <= tx_bits + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // ---------------- RX sync + FSM ----------------
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_s3;
    logic          rx_fall;
    uart_state_t   rx_state;
    uart_state_t   rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bits;
    logic [7:0]    rx_shift;
    logic          rx_tick;
    logic          rx_land;
    logic          rx_ferr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall = rx_s3 && !rx_s2;

    // START counts only half a bit so later samples land mid-bit.
    assign rx_tick = (rx_state == S_START) ?
                     (rx_cnt == HALF_LAST) :
                     (rx_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rx_state <= S_IDLE;
        else
            rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            S_IDLE:
                if (rx_fall)
                    rx_next = S_START;
            S_START:
                if (rx_tick)
                    rx_next = rx_s2 ? S_IDLE : S_DATA;
            S_DATA:
                if (rx_tick && rx_bits == 3'd7)
                    rx_next = S_STOP;
            S_STOP:
                if (rx_tick)
                    rx_next = S_IDLE;
        endcase
    end

    always_comb begin
        rx_land = 1'b0;
        rx_ferr = 1'b0;
        if (rx_state == S_STOP && rx_tick) begin
            rx_land = rx_s2;
            rx_ferr = !rx_s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else if (rx_state == S_IDLE) begin
            rx_cnt  <= '0;
            rx_bits <= '0;
        end else if (rx_tick) begin
            rx_cnt <= '0;
            if (rx_state == S_DATA) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bits  <= rx_bits + 3'd1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1'b1;
        end
    end

    // ---------------- registers ----------------
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        rx_ovr;
    logic        frm_err;
    logic        tx_ovf;
    logic [31:0] status;

    always_comb begin
        status              = '0;
        status[ST_TX_IDLE]  = fifo_empty && (tx_state == S_IDLE);
        status[ST_TX_FULL]  = fifo_full;
        status[ST_RX_VALID] = rx_valid;
        status[ST_RX_OVR]   = rx_ovr;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_FRM_ERR]  = frm_err;
    end

    // Sticky flags: a set event outranks a same-cycle W1C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            frm_err  <= 1'b0;
            tx_ovf   <= 1'b0;
            io_din   <= '0;
        end else begin
            if (rx_land)
                rx_byte <= rx_shift;

            if (rx_land)
                rx_valid <= 1'b1;
            else if (rd_data)
                rx_valid <= 1'b0;

            if (rx_land && rx_valid)
                rx_ovr <= 1'b1;
            else if (wr_stat && dout[ST_RX_OVR])
                rx_ovr <= 1'b0;

            if (rx_ferr)
                frm_err <= 1'b1;
            else if (wr_stat && dout[ST_FRM_ERR])
                frm_err <= 1'b0;

            if (tx_drop)
                tx_ovf <= 1'b1;
            else if (wr_stat && dout[ST_TX_OVF])
                tx_ovf <= 1'b0;

            if (io_rd) begin
                if (sel_data)
                    io_din <= {24'b0, rx_byte};
                else if (sel_stat)
                    io_din <= status;
                else
                    io_din <= '0;
            end
        end
    end

endmodule

// File: tb/tb_io_uart_port.sv
// Directed self-checking bench for io_uart_port with a TX scoreboard.
// Ports exercised: bus read/write, uart_tx frames, uart_rx frames.
module tb_io_uart_port;

    localparam int CPB = 4;

    logic        clk;
    logic        reset;
    logic [15:0] memIo_addr;
    logic        io_rd;
    logic        io_wr;
    logic [31:0] wdata;
    logic [31:0] io_din;
    logic        uart_rx;
    logic        uart_tx;

    int          checks;
    int          passes;
    logic [7:0]  tx_q[$];
    logic        mon_en;
    logic [31:0] r;
    logic [9:0]  fr;

    io_uart_port #(
        .CLKS_PER_BIT(CPB),
        .TX_DEPTH    (4),
        .BASE_ADDR   (16'h1000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memIo_addr(memIo_addr),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .dout      (wdata),
        .io_din    (io_din),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a,
                             input logic [31:0] d);
        memIo_addr = a;
        wdata      = d;
        io_wr      = 1'b1;
        @(negedge clk);
        io_wr      = 1'b0;
    endtask

    task automatic bus_read(input  logic [15:0] a,
                            output logic [31:0] d);
        memIo_addr = a;
        io_rd      = 1'b1;
        @(negedge clk);
        io_rd      = 1'b0;
        d          = io_din;
    endtask

    task automatic send_rx(input logic [7:0] b,
                           input logic sb);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = sb;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, tx_q.size(), 0);
        repeat (CPB + 2) @(negedge clk);
    endtask

    // TX monitor: decode frames mid-bit, compare with scoreboard.
    initial begin : tx_mon
        logic       prev;
        logic [7:0] got;
        logic [7:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !uart_tx) begin
                @(negedge clk);
                check("tx_start_bit", uart_tx, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = uart_tx;
                end
                repeat (CPB) @(negedge clk);
                check("tx_stop_bit", uart_tx, 1'b1);
                check("tx_frame_expected",
                      tx_q.size() > 0, 1);
                if (tx_q.size() > 0) begin
                    exp = tx_q.pop_front();
                    check("tx_byte", got, exp);
                end
            end
            prev = uart_tx;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        passes     = 0;
        reset      = 1'b1;
        io_rd      = 1'b0;
        io_wr      = 1'b0;
        memIo_addr = '0;
        wdata      = '0;
        uart_rx    = 1'b1;
        mon_en     = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_io_din", io_din, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        bus_read(16'h1004, r);
        check("rst_status", r, 32'h1);
        bus_read(16'h1008, r);
        check("unmapped_rd", r, 32'h0);
        bus_write(16'h1008, 32'h55);
        bus_write(16'h1001, 32'h55);
        bus_read(16'h1004, r);
        check("unmapped_wr", r, 32'h1);

        // single byte A5, cycle-exact waveform
        fr = {1'b1, 8'hA5, 1'b0};
        tx_q.push_back(8'hA5);
        bus_write(16'h1000, 32'hA5);
        check("tx_pre_start", uart_tx, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 10 * CPB; i++) begin
            check($sformatf("a5_cyc%0d", i),
                  uart_tx, fr[i / CPB]);
            @(negedge clk);
        end
        check("a5_after", uart_tx, 1'b1);
        wait_drain("a5_drain");
        bus_read(16'h1004, r);
        check("a5_status", r, 32'h1);
        repeat (5) @(negedge clk);
        check("din_hold", io_din, 32'h1);

        // five back-to-back writes: fills FIFO, no overflow
        for (int i = 1; i <= 5; i++) begin
            tx_q.push_back(8'(i));
            bus_write(16'h1000, 32'(i));
        end
        bus_read(16'h1004, r);
        check("five_status", r, 32'h2);
        wait_drain("five_drain");
        bus_read(16'h1004, r);
        check("five_idle", r, 32'h1);

        // six back-to-back writes: last byte dropped
        for (int i = 0; i < 6; i++) begin
            if (i < 5)
                tx_q.push_back(8'(8'h11 + i));
            bus_write(16'h1000, 32'(8'h11 + i));
        end
        bus_read(16'h1004, r);
        check("six_status", r, 32'h12);
        wait_drain("six_drain");
        bus_read(16'h1004, r);
        check("six_ovf_sticky", r, 32'h11);
        bus_write(16'h1004, 32'h10);
        bus_read(16'h1004, r);
        check("ovf_w1c", r, 32'h1);

        // RX single frame
        send_rx(8'h3C, 1'b1);
        repeat (6) @(negedge clk);
        bus_read(16'h1004, r);
        check("rx_valid_set", r, 32'h5);
        bus_read(16'h1000, r);
        check("rx_data", r, 32'h3C);
        bus_read(16'h1004, r);
        check("rx_valid_clr", r, 32'h1);

        // RX overrun
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (6) @(negedge clk);
        bus_read(16'h1004, r);
        check("rx_ovr_status", r, 32'hD);
        bus_read(16'h1000, r);
        check("rx_ovr_data", r, 32'h22);
        bus_write(16'h1004, 32'h08);
        bus_read(16'h1004, r);
        check("rx_ovr_w1c", r, 32'h1);

        // RX framing error
        send_rx(8'h5A, 1'b0);
        repeat (6) @(negedge clk);
        bus_read(16'h1004, r);
        check("frm_err_status", r, 32'h21);
        bus_write(16'h1004, 32'h20);
        bus_read(16'h1004, r);
        check("frm_err_w1c", r, 32'h1);

        // reset mid TX frame
        mon_en = 1'b0;
        bus_write(16'h1000, 32'h77);
        bus_write(16'h1000, 32'h78);
        repeat (12) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_tx", uart_tx, 1'b1);
        @(negedge clk);
        check("rst_mid_din", io_din, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        bus_read(16'h1004, r);
        check("rst_mid_status", r, 32'h1);
        repeat (20) @(negedge clk);
        check("rst_fifo_lost", uart_tx, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
